hs32_fetch: RTL and testbench



---
 rtl/hs32_pkg.sv | 32 +++
 rtl/hs32_fifo.sv | 76 +++++++
 rtl/hs32_fetch.sv | 166 ++++++++++++++++
 tb/tb_hs32_fetch.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hs32_pkg.sv
// hs32_pkg: shared types for the hs32 front end.
// Holds the instruction word type seen by decode, the prefetch FIFO entry,
// the reset fetch address and the fetch FSM encoding.
package hs32_pkg;

    // Instruction word as handed from fetch to decode.
    typedef logic [31:0] hs32_instr;

    // One prefetch FIFO entry: the word and the address it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        hs32_instr   instr;
    } hs32_fetch_ent_t;

    localparam logic [31:0] HS32_RESET_PC      = 32'h0000_0000;
    localparam logic [31:0] HS32_PC_STEP       = 32'd4;
    localparam logic [31:0] HS32_PC_ALIGN_MASK = 32'hFFFF_FFFC;

    // IDLE: nothing outstanding. REQ: live request. KILL: stale request
    // still on the bus whose data must be thrown away.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        KILL = 2'd2
    } hs32_fetch_state_e;

    // Fetch addresses are word aligned; low two bits are always dropped.
    function automatic logic [31:0] hs32_align_pc(input logic [31:0] pc);
        return pc & HS32_PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/hs32_fifo.sv
// hs32_fifo: synchronous FIFO with clear, used as the fetch prefetch buffer.
// clear_i overrides push and pop in the same cycle. A push while full is
// accepted only if a pop happens in the same cycle (count unchanged).
// Reset is asynchronous, active low.
module hs32_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [63:0]
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   push_i,
    input  T                       wdata_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    output T                       rdata_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    T              r_mem [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = pop_i && !w_empty;
    assign w_push  = push_i && (!w_full || w_pop);

    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign count_o = r_count;
    assign rdata_o = r_mem[r_rd_ptr];

    // Storage: write the pushed entry at the write pointer.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push && !clear_i) begin
            r_mem[r_wr_ptr] <= wdata_i;
        end
    end

    // Pointers and occupancy; clear empties the buffer outright.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clear_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

endmodule

// File: rtl/hs32_fetch.sv
// hs32_fetch: instruction fetch / prefetch stage feeding decode.
// Issues sequential word fetches on a single-outstanding req/ack bus, buffers
// returned words with their PC, and restarts at a redirect PC on flush_i.
// Optional macro HS32_FETCH_BYPASS_EN: an ack into an empty buffer is shown
// to decode in the same cycle (zero fetch-to-decode latency).
//
// Decode handshake: a word moves to decode at a clock edge where
// valid_o && ready_i; while valid_o=1 and ready_i=0, data_o/pc_o hold.
// Bus handshake: ibus_req_o/ibus_addr_o hold until the cycle ibus_ack_i=1,
// which also carries ibus_data_i.
module hs32_fetch
    import hs32_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = HS32_RESET_PC
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    output logic              ibus_req_o,
    output logic [31:0]       ibus_addr_o,
    input  logic              ibus_ack_i,
    input  logic [31:0]       ibus_data_i,
    input  logic              flush_i,
    input  logic [31:0]       flush_pc_i,
    output hs32_instr         data_o,
    output logic [31:0]       pc_o,
    output logic              valid_o,
    input  logic              ready_i,
    output hs32_fetch_state_e dbg_state_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    hs32_fetch_state_e r_state;
    hs32_fetch_state_e w_state_next;
    logic [31:0]       r_pc;
    logic [31:0]       r_redirect_pc;

    logic              w_ack_req;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_count_next;
    logic [31:0]       w_flush_pc;
    hs32_fetch_ent_t   w_push_ent;
    hs32_fetch_ent_t   w_head;

    assign w_flush_pc  = hs32_align_pc(flush_pc_i);
    assign dbg_state_o = r_state;

    hs32_fifo #(
        .DEPTH (DEPTH),
        .T     (hs32_fetch_ent_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (w_push),
        .wdata_i (w_push_ent),
        .pop_i   (w_pop),
        .clear_i (flush_i),
        .rdata_o (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    // FSM state register.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: credit (buffered + in flight < DEPTH) gates new requests.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                // A flush empties the buffer, so credit is guaranteed.
                if (flush_i || !w_full) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (ibus_ack_i) begin
                    if (flush_i) begin
                        w_state_next = REQ;
                    end else if (w_count_next < CW'(DEPTH)) begin
                        w_state_next = REQ;
                    end else begin
                        w_state_next = IDLE;
                    end
                end else if (flush_i) begin
                    // Request cannot be withdrawn; wait out its ack.
                    w_state_next = KILL;
                end
            end
            KILL: begin
                if (ibus_ack_i) begin
                    w_state_next = REQ;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs and FIFO controls derived from state and bus/decode inputs.
    always_comb begin
        ibus_req_o  = (r_state != IDLE);
        ibus_addr_o = r_pc;
        w_ack_req   = (r_state == REQ) && ibus_ack_i;
`ifdef HS32_FETCH_BYPASS_EN
        w_bypass    = w_empty && w_ack_req && !flush_i;
`else
        w_bypass    = 1'b0;
`endif
        valid_o      = !w_empty || w_bypass;
        data_o       = w_bypass ? ibus_data_i : w_head.instr;
        pc_o         = w_bypass ? r_pc : w_head.pc;
        // Flush clears the FIFO anyway; a concurrent pop is still a transfer.
        w_pop        = !w_empty && ready_i;
        // A bypassed word taken by decode this cycle is never stored.
        w_push       = w_ack_req && !flush_i && !(w_bypass && ready_i);
        w_push_ent   = '{pc: r_pc, instr: ibus_data_i};
        w_count_next = w_count + CW'(w_push) - CW'(w_pop);
    end

    // Fetch PC and latched redirect target.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_pc          <= RESET_PC;
            r_redirect_pc <= RESET_PC;
        end else begin
            case (r_state)
                IDLE: begin
                    if (flush_i) begin
                        r_pc <= w_flush_pc;
                    end
                end
                REQ: begin
                    if (ibus_ack_i) begin
                        r_pc <= flush_i ? w_flush_pc : (r_pc + HS32_PC_STEP);
                    end else if (flush_i) begin
                        r_redirect_pc <= w_flush_pc;
                    end
                end
                KILL: begin
                    if (ibus_ack_i) begin
                        r_pc <= flush_i ? w_flush_pc : r_redirect_pc;
                    end else if (flush_i) begin
                        r_redirect_pc <= w_flush_pc;
                    end
                end
                default: begin
                    r_pc <= r_pc;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hs32_fetch.sv
// tb_hs32_fetch: directed bench for hs32_fetch (default build and
// HS32_FETCH_BYPASS_EN build). Bus model acks with data equal to address.
module tb_hs32_fetch;
    import hs32_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn_i;

    // main instance (RESET_PC = 0, DEPTH = 4)
    logic              ibus_req_o;
    logic [31:0]       ibus_addr_o;
    logic              ibus_ack_i;
    logic [31:0]       ibus_data_i;
    logic              flush_i;
    logic [31:0]       flush_pc_i;
    hs32_instr         data_o;
    logic [31:0]       pc_o;
    logic              valid_o;
    logic              ready_i;
    hs32_fetch_state_e dbg_state_o;

    // wrap instance (RESET_PC = 0xFFFF_FFF8)
    logic              b_req;
    logic [31:0]       b_addr;
    logic              b_ack;
    logic [31:0]       b_data;
    logic              b_flush;
    logic [31:0]       b_flush_pc;
    hs32_instr         b_data_o;
    logic [31:0]       b_pc;
    logic              b_valid;
    logic              b_ready;
    hs32_fetch_state_e b_state;

    hs32_fetch u_dut (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .ibus_req_o  (ibus_req_o),
        .ibus_addr_o (ibus_addr_o),
        .ibus_ack_i  (ibus_ack_i),
        .ibus_data_i (ibus_data_i),
        .flush_i     (flush_i),
        .flush_pc_i  (flush_pc_i),
        .data_o      (data_o),
        .pc_o        (pc_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .dbg_state_o (dbg_state_o)
    );

    hs32_fetch #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .clk_i       (clk),
        .rstn_i      (rstn_i),
        .ibus_req_o  (b_req),
        .ibus_addr_o (b_addr),
        .ibus_ack_i  (b_ack),
        .ibus_data_i (b_data),
        .flush_i     (b_flush),
        .flush_pc_i  (b_flush_pc),
        .data_o      (b_data_o),
        .pc_o        (b_pc),
        .valid_o     (b_valid),
        .ready_i     (b_ready),
        .dbg_state_o (b_state)
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];      // expected pcs (== data) transferred to decode
    logic [31:0] ack_exp_q[$];  // expected addresses of acked requests
    logic [31:0] b_exp_q[$];
    logic [31:0] b_ack_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;
    int first_valid;
    int first_req;
    logic ack_en;
    logic b_en;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a negedge: drive the bus response, sample what the next
    // posedge will see, then advance to the next negedge.
    task automatic cycle();
        logic [31:0] e;
        ibus_ack_i  = ack_en && ibus_req_o;
        ibus_data_i = ibus_addr_o;
        b_ack       = b_en && b_req;
        b_data      = b_addr;
        #1;
        if (ibus_req_o && ibus_ack_i) begin
            check("ack_expected", 32'(ack_exp_q.size() != 0), 32'd1);
            if (ack_exp_q.size() != 0) begin
                e = ack_exp_q.pop_front();
                check("ack_addr", ibus_addr_o, e);
            end
        end
        if (valid_o && ready_i) begin
            check("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("xfer_pc", pc_o, e);
                check("xfer_data", data_o, e);
            end
        end
        if (b_req && b_ack) begin
            check("wrap_ack_expected", 32'(b_ack_q.size() != 0), 32'd1);
            if (b_ack_q.size() != 0) begin
                e = b_ack_q.pop_front();
                check("wrap_ack_addr", b_addr, e);
            end
        end
        if (b_valid && b_ready) begin
            check("wrap_xfer_expected", 32'(b_exp_q.size() != 0), 32'd1);
            if (b_exp_q.size() != 0) begin
                e = b_exp_q.pop_front();
                check("wrap_xfer_pc", b_pc, e);
            end
        end
        if (valid_o && first_valid < 0) first_valid = cyc;
        if (ibus_req_o && first_req < 0) first_req = cyc;
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rstn_i      = 1'b0;
        ack_en      = 1'b0;
        b_en        = 1'b0;
        ready_i     = 1'b0;
        flush_i     = 1'b0;
        flush_pc_i  = '0;
        ibus_ack_i  = 1'b0;
        b_ack       = 1'b0;
        exp_q.delete();
        ack_exp_q.delete();
        b_exp_q.delete();
        b_ack_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic release_reset();
        rstn_i      = 1'b1;
        cyc         = 0;
        first_valid = -1;
        first_req   = -1;
    endtask

    task automatic end_test(input string tag);
        check({tag, "_acks_left"}, 32'(ack_exp_q.size()), 32'd0);
        check({tag, "_xfers_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rstn_i      = 1'b0;
        ibus_ack_i  = 1'b0;
        ibus_data_i = '0;
        flush_i     = 1'b0;
        flush_pc_i  = '0;
        ready_i     = 1'b0;
        b_ack       = 1'b0;
        b_data      = '0;
        b_flush     = 1'b0;
        b_flush_pc  = '0;
        b_ready     = 1'b1;
        ack_en      = 1'b0;
        b_en        = 1'b0;
        cyc         = 0;
        first_valid = -1;
        first_req   = -1;
        repeat (2) @(negedge clk);

        // reset values
        check("rst_req", 32'(ibus_req_o), 32'd0);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_addr", ibus_addr_o, 32'h0);
        check("rst_data", data_o, 32'h0);
        check("rst_pc", pc_o, 32'h0);
        check("rst_state", 32'(dbg_state_o), 32'(IDLE));
        check("rst_wrap_addr", b_addr, 32'hFFFF_FFF8);

        // streaming with single-cycle acks and ready held high
        apply_reset();
        for (int i = 0; i < 7; i++) ack_exp_q.push_back(32'(4 * i));
`ifdef HS32_FETCH_BYPASS_EN
        for (int i = 0; i < 7; i++) exp_q.push_back(32'(4 * i));
`else
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
`endif
        ready_i = 1'b1;
        ack_en  = 1'b1;
        release_reset();
        repeat (8) cycle();
        check("first_req_cycle", 32'(first_req), 32'd1);
`ifdef HS32_FETCH_BYPASS_EN
        check("first_valid_cycle", 32'(first_valid), 32'd1);
`else
        check("first_valid_cycle", 32'(first_valid), 32'd2);
`endif
        end_test("stream");

        // decode stall fills the buffer, then drains
        apply_reset();
        for (int i = 0; i < 8; i++) ack_exp_q.push_back(32'(4 * i));
        for (int i = 0; i < 6; i++) exp_q.push_back(32'(4 * i));
        ready_i = 1'b0;
        ack_en  = 1'b1;
        release_reset();
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (valid_o) begin
                check("stall_data", data_o, 32'h0);
                check("stall_pc", pc_o, 32'h0);
            end
        end
        check("stall_req_low", 32'(ibus_req_o), 32'd0);
        check("stall_acks_taken", 32'(ack_exp_q.size()), 32'd4);
        ready_i = 1'b1;
        repeat (6) cycle();
        end_test("stall");

        // flush while a request to 0x8 waits for its ack (low bits ignored)
        apply_reset();
        ack_exp_q = '{32'h0, 32'h4, 32'h8, 32'h100, 32'h104};
`ifdef HS32_FETCH_BYPASS_EN
        exp_q = '{32'h0, 32'h4, 32'h100, 32'h104};
`else
        exp_q = '{32'h0, 32'h4, 32'h100};
`endif
        ready_i = 1'b1;
        ack_en  = 1'b1;
        release_reset();
        repeat (3) cycle();
        ack_en = 1'b0;
        cycle();
        flush_i    = 1'b1;
        flush_pc_i = 32'h0000_0103;
        cycle();
        flush_i = 1'b0;
        check("kill_state", 32'(dbg_state_o), 32'(KILL));
        check("kill_req", 32'(ibus_req_o), 32'd1);
        check("kill_addr", ibus_addr_o, 32'h8);
        cycle();
        check("kill_state_hold", 32'(dbg_state_o), 32'(KILL));
        check("kill_addr_hold", ibus_addr_o, 32'h8);
        ack_en = 1'b1;
        cycle();
        check("kill_done_state", 32'(dbg_state_o), 32'(REQ));
        check("kill_redirect_addr", ibus_addr_o, 32'h100);
        repeat (2) cycle();
        end_test("kill");

        // flush in the same cycle as the ack for 0x4
        apply_reset();
        ack_exp_q = '{32'h0, 32'h4, 32'h200, 32'h204, 32'h208};
`ifdef HS32_FETCH_BYPASS_EN
        exp_q = '{32'h0, 32'h200, 32'h204, 32'h208};
`else
        exp_q = '{32'h0, 32'h200, 32'h204};
`endif
        ready_i = 1'b1;
        ack_en  = 1'b1;
        release_reset();
        repeat (2) cycle();
        flush_i    = 1'b1;
        flush_pc_i = 32'h200;
        cycle();
        flush_i = 1'b0;
        check("ackflush_state", 32'(dbg_state_o), 32'(REQ));
        check("ackflush_addr", ibus_addr_o, 32'h200);
`ifndef HS32_FETCH_BYPASS_EN
        check("ackflush_valid", 32'(valid_o), 32'd0);
`endif
        repeat (3) cycle();
        end_test("ackflush");

        // PC wrap from RESET_PC = 0xFFFF_FFF8
        apply_reset();
        b_ack_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
`ifdef HS32_FETCH_BYPASS_EN
        b_exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0};
`else
        b_exp_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC};
`endif
        b_en = 1'b1;
        release_reset();
        repeat (4) cycle();
        b_en = 1'b0;
        check("wrap_acks_left", 32'(b_ack_q.size()), 32'd0);
        check("wrap_xfers_left", 32'(b_exp_q.size()), 32'd0);

        // asynchronous reset while in KILL, late ack ignored
        apply_reset();
        ack_exp_q = '{32'h0};
        exp_q     = '{32'h0};
        ready_i = 1'b1;
        ack_en  = 1'b1;
        release_reset();
        repeat (2) cycle();
        ack_en     = 1'b0;
        flush_i    = 1'b1;
        flush_pc_i = 32'h300;
        cycle();
        flush_i = 1'b0;
        check("rkill_state", 32'(dbg_state_o), 32'(KILL));
        check("rkill_addr", ibus_addr_o, 32'h4);
        #2;
        rstn_i = 1'b0;
        #1;
        check("rkill_req", 32'(ibus_req_o), 32'd0);
        check("rkill_valid", 32'(valid_o), 32'd0);
        check("rkill_rst_addr", ibus_addr_o, 32'h0);
        check("rkill_rst_state", 32'(dbg_state_o), 32'(IDLE));
        check("rkill_rst_data", data_o, 32'h0);
        check("rkill_rst_pc", pc_o, 32'h0);
        ibus_ack_i  = 1'b1;
        ibus_data_i = 32'h4;
        @(negedge clk);
        ibus_ack_i = 1'b0;
        end_test("rkill_pre");
        ack_exp_q = '{32'h0, 32'h4, 32'h8};
`ifdef HS32_FETCH_BYPASS_EN
        exp_q = '{32'h0, 32'h4, 32'h8};
`else
        exp_q = '{32'h0, 32'h4};
`endif
        ack_en  = 1'b1;
        ready_i = 1'b1;
        release_reset();
        repeat (4) cycle();
        end_test("rkill_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

endmodule
